imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Two-requester arbiter and sequencer for the single-ported instruction memory of the multicycle core. It shares the word-addressed program memory between the CPU fetch unit (read-only) and a program loader/debug port (read/write). It grants one access per cycle and returns registered responses one cycle later. It also provides a loader lock for downloading programs without fetch interference, and a saturating fetch-stall counter.

## Interface
- AW, 8, word-index width of memory (2^AW words; 256 default)
- DW, 32, data width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch request; f_addr held stable until granted
- f_addr  in  32  fetch byte address (pc)
- f_gnt  out  1  fetch granted this cycle (combinational)
- f_rvalid  out  1  fetch response valid (registered)
- f_rdata  out  DW  fetch read data
- f_err  out  1  fetch response is an address error
- l_req  in  1  loader request; l_we/l_addr/l_wdata held until granted
- l_we  in  1  1 = write, 0 = read
- l_addr  in  32  loader byte address
- l_wdata  in  DW  loader write data
- l_lock  in  1  while 1, fetch is never granted
- l_gnt  out  1  loader granted this cycle (combinational)
- l_rvalid  out  1  loader response valid (registered)
- l_rdata  out  DW  loader read data (0 for writes)
- l_err  out  1  loader response is an address error
- mem_addr  out  AW  word index to memory
- mem_we  out  1  memory write enable
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory combinational read data for mem_addr
- f_stall_cnt  out  16  saturating count of stalled fetch cycles

## Operation
- Eligibility: fetch eligible = f_req & ~l_lock; loader eligible = l_req.
- Single eligible requester is granted immediately.
- Both eligible: round-robin. Grant the requester that did not win the previous grant (last_gnt register). last_gnt updates only on cycles with a grant.
- At most one of f_gnt/l_gnt is high in any cycle.
- Address check per requester: error if addr[1:0] != 0 or addr[31:AW+2] != 0.
- Granted, no error: mem_addr = addr[AW+1:2]. mem_we = l_we only when the loader is the winner. mem_wdata = l_wdata.
- Granted with error: the slot is consumed and counts as a win for round-robin, but mem_we = 0.
- No grant: mem_addr = 0, mem_we = 0, mem_wdata = 0.
- Response (registered, next cycle after grant):
  - Winner's rvalid = 1.
  - Read: rdata = mem_rdata sampled at the grant edge.
  - Write: rdata = 0.
  - Error: err = 1, rdata = 0.
  - The non-winner's rvalid/err/rdata = 0 that cycle.
- f_stall_cnt increments each cycle with f_req = 1 and f_gnt = 0, including cycles blocked by l_lock. It saturates at 0xFFFF.

## Timing
- Reset (async assert, sync-free deassert handling):
  - f_rvalid, l_rvalid, f_err, l_err = 0; f_rdata, l_rdata = 0; f_stall_cnt = 0.
  - last_gnt = loader, so fetch wins the first contended cycle.
- Grant is combinational in cycle N. Response is valid in cycle N+1, exactly one cycle wide. Latency is fixed at 1.
- Back-to-back grants are allowed every cycle (full throughput). Responses pipeline accordingly.
- A requester that keeps req high after its grant is a new request in the next cycle.
- Read-after-write: loader write granted in cycle N, read of the same word granted in N+1, returns the new data in N+2.
- l_lock takes effect in the same cycle it is sampled. Raising l_lock does not cancel a response already in flight.
- Reset mid-operation clears pending responses. No rvalid is produced for a grant issued in the cycle reset asserts.

## Test plan
- Reset, then f_req with f_addr = 0x8 and mem word 2 = 0x00500093 -> f_gnt same cycle, mem_addr = 2; next cycle f_rvalid = 1, f_rdata = 0x00500093, f_err = 0.
- f_req and l_req both held high for 4 cycles after reset -> grants alternate F, L, F, L; 4 responses, each one cycle after its grant.
- l_lock = 1, l_we = 1, l_addr = 0x10, l_wdata = 0xDEADBEEF, f_req held 3 cycles -> no f_gnt; mem_we = 1 and mem_addr = 4 in the loader cycle; f_stall_cnt = 3; a subsequent fetch of 0x10 returns 0xDEADBEEF.
- f_addr = 0x6 (misaligned), then f_addr = 0x400 with AW = 8 (out of range) -> each granted with mem_we = 0; f_rvalid = 1, f_err = 1, f_rdata = 0.
- f_req held with l_lock = 1 for 70000 cycles -> f_stall_cnt stops at 0xFFFF. Assert rst_n low mid-stream with a response pending -> all outputs 0 immediately, f_stall_cnt = 0.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-ported instruction memory between the CPU
// fetch unit and the program loader. One grant per cycle, registered
// responses one cycle later, loader lock, and a saturating fetch-stall count.
module imem_arbiter #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic [31:0]   f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    output logic          f_err,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [31:0]   l_addr,
    input  logic [DW-1:0] l_wdata,
    input  logic          l_lock,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
    output logic          l_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   f_stall_cnt
);

    typedef enum logic {
        OWN_FETCH  = 1'b0,
        OWN_LOADER = 1'b1
    } owner_e;

    owner_e          last_gnt_q, last_gnt_d;
    logic            f_rvalid_q, f_rvalid_d;
    logic            l_rvalid_q, l_rvalid_d;
    logic            f_err_q, f_err_d;
    logic            l_err_q, l_err_d;
    logic [DW-1:0]   f_rdata_q, f_rdata_d;
    logic [DW-1:0]   l_rdata_q, l_rdata_d;
    logic [15:0]     stall_q, stall_d;

    logic            f_elig, l_elig, f_win, l_win;
    logic            f_bad, l_bad, sel_bad;
    logic [31:0]     sel_addr;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
    endfunction

    // Arbitration: round-robin on contention. Grants are held off while
    // rst_n is low so no request issued during reset produces a response.
    always_comb begin
        f_bad    = addr_bad(f_addr);
        l_bad    = addr_bad(l_addr);
        f_elig   = rst_n & f_req & ~l_lock;
        l_elig   = rst_n & l_req;
        f_win    = f_elig & (~l_elig | (last_gnt_q == OWN_LOADER));
        l_win    = l_elig & ~f_win;
        sel_addr = f_win ? f_addr : l_addr;
        sel_bad  = f_win ? f_bad : l_bad;
        last_gnt_d = last_gnt_q;
        if (f_win) begin
            last_gnt_d = OWN_FETCH;
        end else if (l_win) begin
            last_gnt_d = OWN_LOADER;
        end
    end

    // Memory port drive: only a granted, well-formed access reaches memory.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if ((f_win | l_win) & ~sel_bad) begin
            mem_addr  = sel_addr[AW+1:2];
            mem_we    = l_win & l_we;
            mem_wdata = l_wdata;
        end
    end

    // Next-cycle responses and stall counter update.
    always_comb begin
        f_rvalid_d = f_win;
        f_err_d    = f_win & f_bad;
        f_rdata_d  = (f_win & ~f_bad) ? mem_rdata : '0;
        l_rvalid_d = l_win;
        l_err_d    = l_win & l_bad;
        l_rdata_d  = (l_win & ~l_bad & ~l_we) ? mem_rdata : '0;
        stall_d    = stall_q;
        if (f_req & ~f_win & (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // State registers; last_gnt resets to loader so fetch wins first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= OWN_LOADER;
            f_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
            f_err_q    <= 1'b0;
            l_err_q    <= 1'b0;
            f_rdata_q  <= '0;
            l_rdata_q  <= '0;
            stall_q    <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            f_rvalid_q <= f_rvalid_d;
            l_rvalid_q <= l_rvalid_d;
            f_err_q    <= f_err_d;
            l_err_q    <= l_err_d;
            f_rdata_q  <= f_rdata_d;
            l_rdata_q  <= l_rdata_d;
            stall_q    <= stall_d;
        end
    end

    assign f_gnt       = f_win;
    assign l_gnt       = l_win;
    assign f_rvalid    = f_rvalid_q;
    assign l_rvalid    = l_rvalid_q;
    assign f_err       = f_err_q;
    assign l_err       = l_err_q;
    assign f_rdata     = f_rdata_q;
    assign l_rdata     = l_rdata_q;
    assign f_stall_cnt = stall_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural 256-word memory.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req, l_req, l_we, l_lock;
    logic [31:0] f_addr, l_addr, l_wdata;
    logic        f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, l_err, mem_we;
    logic [31:0] f_rdata, l_rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;
    logic [15:0] f_stall_cnt;

    logic [31:0] mem [256];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.AW(8), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .l_err(l_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .f_stall_cnt(f_stall_cnt)
    );

    // Memory model: combinational read, write on the rising edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        f_req = 0; l_req = 0; l_we = 0; l_lock = 0;
        f_addr = 0; l_addr = 0; l_wdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
        #1;
    endtask

    initial begin
        logic [3:0] exp_f;
        exp_f = 4'b0101;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[2] = 32'h0050_0093;
        mem[255] = 32'hCAFE_F00D;

        // Reset values
        idle_inputs();
        rst_n = 0;
        #2;
        chk("rst_f_rvalid", {31'd0, f_rvalid}, 0);
        chk("rst_l_rvalid", {31'd0, l_rvalid}, 0);
        chk("rst_f_rdata", f_rdata, 0);
        chk("rst_stall", {16'd0, f_stall_cnt}, 0);
        step();
        rst_n = 1;
        #1;

        // Single fetch of word 2
        f_req = 1; f_addr = 32'h8;
        #1;
        chk("fetch_gnt", {31'd0, f_gnt}, 1);
        chk("fetch_mem_addr", {24'd0, mem_addr}, 2);
        chk("fetch_mem_we", {31'd0, mem_we}, 0);
        step();
        f_req = 0;
        chk("fetch_rvalid", {31'd0, f_rvalid}, 1);
        chk("fetch_rdata", f_rdata, 32'h0050_0093);
        chk("fetch_err", {31'd0, f_err}, 0);
        step();
        chk("fetch_rvalid_1wide", {31'd0, f_rvalid}, 0);

        // Contention: F, L, F, L
        do_reset();
        f_req = 1; f_addr = 32'h8; l_req = 1; l_addr = 32'h8;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_f_gnt", {31'd0, f_gnt}, {31'd0, exp_f[i]});
            chk("rr_l_gnt", {31'd0, l_gnt}, {31'd0, ~exp_f[i]});
            step();
            chk("rr_f_rvalid", {31'd0, f_rvalid}, {31'd0, exp_f[i]});
            chk("rr_l_rvalid", {31'd0, l_rvalid}, {31'd0, ~exp_f[i]});
        end
        chk("rr_l_rdata", l_rdata, 32'h0050_0093);
        chk("rr_stall", {16'd0, f_stall_cnt}, 2);
        idle_inputs();

        // Lock: loader writes word 4 while fetch is blocked for 3 cycles
        do_reset();
        l_lock = 1; f_req = 1; f_addr = 32'h10;
        l_req = 1; l_we = 1; l_addr = 32'h10; l_wdata = 32'hDEAD_BEEF;
        #1;
        chk("lock_f_gnt", {31'd0, f_gnt}, 0);
        chk("lock_l_gnt", {31'd0, l_gnt}, 1);
        chk("lock_mem_we", {31'd0, mem_we}, 1);
        chk("lock_mem_addr", {24'd0, mem_addr}, 4);
        chk("lock_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        step();
        l_req = 0; l_we = 0;
        chk("lock_l_rvalid", {31'd0, l_rvalid}, 1);
        chk("lock_l_rdata", l_rdata, 0);
        chk("lock_f_rvalid", {31'd0, f_rvalid}, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lock_f_gnt_hold", {31'd0, f_gnt}, 0);
            step();
        end
        chk("lock_stall", {16'd0, f_stall_cnt}, 3);
        l_lock = 0;
        #1;
        chk("raw_f_gnt", {31'd0, f_gnt}, 1);
        chk("raw_mem_addr", {24'd0, mem_addr}, 4);
        step();
        f_req = 0;
        chk("raw_rdata", f_rdata, 32'hDEAD_BEEF);
        chk("raw_stall_kept", {16'd0, f_stall_cnt}, 3);

        // Address errors and the top valid word
        f_req = 1; f_addr = 32'h6;
        #1;
        chk("mis_gnt", {31'd0, f_gnt}, 1);
        chk("mis_mem_we", {31'd0, mem_we}, 0);
        step();
        chk("mis_err", {31'd0, f_err}, 1);
        chk("mis_rvalid", {31'd0, f_rvalid}, 1);
        chk("mis_rdata", f_rdata, 0);
        f_addr = 32'h400;
        #1;
        chk("oor_gnt", {31'd0, f_gnt}, 1);
        step();
        chk("oor_err", {31'd0, f_err}, 1);
        chk("oor_rdata", f_rdata, 0);
        f_addr = 32'h3FC;
        #1;
        chk("top_mem_addr", {24'd0, mem_addr}, 255);
        step();
        f_req = 0;
        chk("top_err", {31'd0, f_err}, 0);
        chk("top_rdata", f_rdata, 32'hCAFE_F00D);
        l_req = 1; l_we = 1; l_addr = 32'h401; l_wdata = 32'h1234_5678;
        #1;
        chk("lerr_gnt", {31'd0, l_gnt}, 1);
        chk("lerr_mem_we", {31'd0, mem_we}, 0);
        step();
        l_req = 0; l_we = 0;
        chk("lerr_err", {31'd0, l_err}, 1);
        chk("lerr_rvalid", {31'd0, l_rvalid}, 1);

        // Saturation of the stall counter
        l_lock = 1; f_req = 1; f_addr = 32'h8;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_stall", {16'd0, f_stall_cnt}, 32'hFFFF);
        step();
        chk("sat_stall_hold", {16'd0, f_stall_cnt}, 32'hFFFF);

        // Reset with a response pending
        l_lock = 0;
        step();
        chk("prst_rvalid", {31'd0, f_rvalid}, 1);
        rst_n = 0;
        #1;
        chk("mrst_rvalid", {31'd0, f_rvalid}, 0);
        chk("mrst_rdata", f_rdata, 0);
        chk("mrst_stall", {16'd0, f_stall_cnt}, 0);
        chk("mrst_gnt", {31'd0, f_gnt}, 0);
        step();
        chk("mrst_no_resp", {31'd0, f_rvalid}, 0);
        rst_n = 1;
        f_req = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
